msg_parser: RTL and testbench

Message-framing block that sits between the packet receive interface (InBus) and downstream message consumers (OutBus). Each InBus packet is a stream of 64-bit big-endian words carrying back-to-back variable-length messages at arbitrary byte offsets. The block splits the stream into individual messages and re-emits each one left-aligned on a word boundary, with start and end markers.

---
 rtl/msg_parser_pkg.sv | 18 +
 rtl/msg_byte_aligner.sv | 58 +++++
 rtl/msg_parser.sv | 149 ++++++++++++++
 tb/tb_msg_parser.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/msg_parser_pkg.sv
// Shared constants and types for the message framer.
package msg_parser_pkg;

  localparam int unsigned HdrBytes = 3;
  localparam int unsigned LenW     = 16;

  localparam logic [7:0] TypeA = 8'h41;
  localparam logic [7:0] TypeB = 8'h42;
  localparam logic [7:0] TypeD = 8'h44;

  typedef enum logic [1:0] {StHdr, StBody, StDrop} state_e;

  // Byte count 1..8 to Mod field; a full word encodes as 0.
  function automatic logic [2:0] mod_enc(input logic [3:0] n);
    return (n == 4'd8) ? 3'd0 : n[2:0];
  endfunction

endpackage

// File: rtl/msg_byte_aligner.sv
// 16-byte left-aligned byte buffer with per-byte packet-end flags.
// Removes a head run of bytes and appends a word in the same cycle.
module msg_byte_aligner (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [4:0]  i_shift,
  input  logic        i_app_en,
  input  logic [63:0] i_app_data,
  input  logic [3:0]  i_app_cnt,
  input  logic        i_app_last,
  input  logic [3:0]  i_head_cnt,
  output logic [63:0] o_head,
  output logic [15:0] o_len,
  output logic [15:0] o_last,
  output logic [4:0]  o_cnt
);

  logic [127:0] r_buf;
  logic [15:0]  r_last;
  logic [4:0]   r_cnt;

  logic [4:0]   w_base;
  logic [4:0]   w_last_pos;
  logic [63:0]  w_app_mask;
  logic [63:0]  w_head_mask;
  logic [127:0] w_app_buf;
  logic [15:0]  w_app_last;

  // Bytes at or beyond r_cnt are kept zero, so append is a plain OR.
  assign w_base      = r_cnt - i_shift;
  assign w_last_pos  = w_base + {1'b0, i_app_cnt} - 5'd1;
  assign w_app_mask  = ~({64{1'b1}} >> {i_app_cnt, 3'b000});
  assign w_app_buf   = {i_app_data & w_app_mask, 64'd0} >> {w_base, 3'b000};
  assign w_app_last  = i_app_last ? (16'h8000 >> w_last_pos) : 16'd0;
  assign w_head_mask = ~({64{1'b1}} >> {i_head_cnt, 3'b000});

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_buf  <= '0;
      r_last <= '0;
      r_cnt  <= '0;
    end else if (i_app_en) begin
      r_buf  <= (r_buf << {i_shift, 3'b000}) | w_app_buf;
      r_last <= (r_last << i_shift) | w_app_last;
      r_cnt  <= w_base + {1'b0, i_app_cnt};
    end else begin
      r_buf  <= r_buf << {i_shift, 3'b000};
      r_last <= r_last << i_shift;
      r_cnt  <= w_base;
    end
  end

  assign o_head = r_buf[127:64] & w_head_mask;
  assign o_len  = r_buf[127:112];
  assign o_last = r_last;
  assign o_cnt  = r_cnt;

endmodule

// File: rtl/msg_parser.sv
// Splits a packet byte stream into messages and emits each one left-aligned,
// one output word per cycle, with start/end markers.
module msg_parser
  import msg_parser_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  output logic        InBus_DataAck,
  input  logic        InBus_LastWord,
  input  logic        InBus_DataValid,
  input  logic [63:0] InBus_Data,
  input  logic [2:0]  InBus_DataMod,
  output logic        OutBus_Valid,
  output logic        OutBus_Start_Msg,
  output logic        OutBus_End_Msg,
  output logic [2:0]  OutBus_Mod,
  output logic [63:0] OutBus_Data
);

  logic [4:0]      w_cnt;
  logic [15:0]     w_last;
  logic [LenW-1:0] w_len;
  logic [63:0]     w_head;
  logic            w_app_en;
  logic [3:0]      w_app_cnt;

  state_e          r_state, w_state_next;
  logic [LenW-1:0] r_rem, w_rem, w_rem_next;
  logic            w_eop;
  logic [3:0]      w_eop_idx;
  logic [4:0]      w_avail;
  logic [4:0]      w_shift;
  logic            w_try, w_emit, w_end;
  logic [3:0]      w_n, w_n8;

  logic            r_valid, r_start, r_end;
  logic [2:0]      r_mod;
  logic [63:0]     r_data;

  assign InBus_DataAck = !reset && (w_cnt <= 5'd8);
  assign w_app_en      = InBus_DataValid && InBus_DataAck;
  assign w_app_cnt     = (InBus_DataMod == 3'd0) ? 4'd8 : {1'b0, InBus_DataMod};

  msg_byte_aligner u_aligner (
    .i_clk      (clk),
    .i_reset    (reset),
    .i_shift    (w_shift),
    .i_app_en   (w_app_en),
    .i_app_data (InBus_Data),
    .i_app_cnt  (w_app_cnt),
    .i_app_last (InBus_LastWord),
    .i_head_cnt (w_n),
    .o_head     (w_head),
    .o_len      (w_len),
    .o_last     (w_last),
    .o_cnt      (w_cnt)
  );

  // First packet-end flag in the buffer bounds the bytes of the current packet.
  always_comb begin
    w_eop     = 1'b0;
    w_eop_idx = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (w_last[15-i]) begin
        w_eop     = 1'b1;
        w_eop_idx = 4'(i);
      end
    end
  end

  assign w_avail = w_eop ? ({1'b0, w_eop_idx} + 5'd1) : w_cnt;
  assign w_rem   = (r_state == StHdr) ? w_len : r_rem;
  assign w_n8    = (w_rem > LenW'(8)) ? 4'd8 : w_rem[3:0];

  always_comb begin
    w_state_next = r_state;
    w_rem_next   = r_rem;
    w_shift      = 5'd0;
    w_try        = 1'b0;
    w_emit       = 1'b0;
    w_end        = 1'b0;
    w_n          = 4'd0;
    case (r_state)
      StHdr: begin
        if (w_eop && (w_avail < 5'(HdrBytes))) begin
          w_shift = w_avail;
        end else if (w_cnt >= 5'(HdrBytes)) begin
          if (w_len < LenW'(HdrBytes)) w_state_next = StDrop;
          else                         w_try        = 1'b1;
        end
      end
      StBody: w_try = 1'b1;
      StDrop: begin
        if (w_eop) begin
          w_shift      = w_avail;
          w_state_next = StHdr;
        end else begin
          w_shift = w_cnt;
        end
      end
      default: w_state_next = StHdr;
    endcase

    if (w_try) begin
      if (w_avail >= {1'b0, w_n8}) begin
        w_emit = 1'b1;
        w_n    = w_n8;
        w_end  = (w_rem == LenW'(w_n8)) || (w_eop && (w_avail == {1'b0, w_n8}));
      end else if (w_eop) begin
        // Packet ends before the message does: truncate at the last byte.
        w_emit = 1'b1;
        w_n    = w_avail[3:0];
        w_end  = 1'b1;
      end
      if (w_emit) begin
        w_shift      = {1'b0, w_n};
        w_rem_next   = w_rem - LenW'(w_n);
        w_state_next = w_end ? StHdr : StBody;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= StHdr;
      r_rem   <= '0;
      r_valid <= 1'b0;
      r_start <= 1'b0;
      r_end   <= 1'b0;
      r_mod   <= 3'd0;
      r_data  <= '0;
    end else begin
      r_state <= w_state_next;
      r_rem   <= w_rem_next;
      r_valid <= w_emit;
      r_start <= w_emit && (r_state == StHdr);
      r_end   <= w_end;
      r_mod   <= w_end ? mod_enc(w_n) : 3'd0;
      r_data  <= w_emit ? w_head : 64'd0;
    end
  end

  assign OutBus_Valid     = r_valid;
  assign OutBus_Start_Msg = r_start;
  assign OutBus_End_Msg   = r_end;
  assign OutBus_Mod       = r_mod;
  assign OutBus_Data      = r_data;

endmodule

// File: tb/tb_msg_parser.sv
// Directed bench for msg_parser: drives packets, collects output words and
// compares them with hand-computed expectations.
module tb_msg_parser;
  import msg_parser_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        InBus_DataAck;
  logic        InBus_LastWord = 1'b0;
  logic        InBus_DataValid = 1'b0;
  logic [63:0] InBus_Data = '0;
  logic [2:0]  InBus_DataMod = '0;
  logic        OutBus_Valid;
  logic        OutBus_Start_Msg;
  logic        OutBus_End_Msg;
  logic [2:0]  OutBus_Mod;
  logic [63:0] OutBus_Data;

  int n_cmp = 0;
  int n_bad = 0;
  logic [68:0] got_q[$];
  logic [68:0] exp_q[$];

  msg_parser dut (
    .clk              (clk),
    .reset            (reset),
    .InBus_DataAck    (InBus_DataAck),
    .InBus_LastWord   (InBus_LastWord),
    .InBus_DataValid  (InBus_DataValid),
    .InBus_Data       (InBus_Data),
    .InBus_DataMod    (InBus_DataMod),
    .OutBus_Valid     (OutBus_Valid),
    .OutBus_Start_Msg (OutBus_Start_Msg),
    .OutBus_End_Msg   (OutBus_End_Msg),
    .OutBus_Mod       (OutBus_Mod),
    .OutBus_Data      (OutBus_Data)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (OutBus_Valid)
      got_q.push_back({OutBus_Start_Msg, OutBus_End_Msg, OutBus_Mod, OutBus_Data});
  end

  function automatic logic [68:0] ow(input logic s, input logic e, input logic [2:0] m,
                                     input logic [63:0] d);
    return {s, e, m, d};
  endfunction

  task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic send_word(input logic [63:0] d, input logic [2:0] m, input logic l);
    bit ok = 1'b0;
    InBus_Data      = d;
    InBus_DataMod   = m;
    InBus_LastWord  = l;
    InBus_DataValid = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (InBus_DataAck) ok = 1'b1;
    end
    if (!ok) chk("ack_timeout", 72'(InBus_DataAck), 72'd1);
    @(posedge clk);
    #1;
    InBus_DataValid = 1'b0;
    InBus_LastWord  = 1'b0;
    InBus_DataMod   = 3'd0;
  endtask

  task automatic settle();
    repeat (20) @(posedge clk);
    #1;
  endtask

  task automatic check_batch(input string tag);
    chk({tag, ".count"}, 72'(got_q.size()), 72'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk($sformatf("%s[%0d]", tag, i), 72'(got_q[i]), 72'(exp_q[i]));
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_state", {InBus_DataAck, OutBus_Valid, OutBus_Start_Msg, OutBus_End_Msg,
                        OutBus_Mod, OutBus_Data}, 72'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("ack_empty", 72'(InBus_DataAck), 72'd1);
    @(posedge clk);
    #1;

    // Single short message.
    exp_q.push_back(ow(1, 1, 4, 64'h000441FF00000000));
    send_word({16'h0004, TypeA, 8'hFF, 32'h0}, 3'd4, 1'b1);
    settle();
    check_batch("single");

    // Two messages in one word.
    exp_q.push_back(ow(1, 1, 4, 64'h000441CC00000000));
    exp_q.push_back(ow(1, 1, 4, 64'h000441AA00000000));
    send_word(64'h000441CC000441AA, 3'd0, 1'b1);
    settle();
    check_batch("two_in_word");

    // Five-word packet: short message then a 32-byte D message.
    exp_q.push_back(ow(1, 1, 4, 64'h0004415500000000));
    exp_q.push_back(ow(1, 0, 0, 64'h0020440123456789));
    exp_q.push_back(ow(0, 0, 0, 64'hABCDEFFEDCBA9876));
    exp_q.push_back(ow(0, 0, 0, 64'h5432100123456789));
    exp_q.push_back(ow(0, 1, 0, 64'hABCDEFFEDEADBEEF));
    send_word(64'h0004415500204401, 3'd0, 1'b0);
    send_word(64'h23456789ABCDEFFE, 3'd0, 1'b0);
    send_word(64'hDCBA987654321001, 3'd0, 1'b0);
    send_word(64'h23456789ABCDEFFE, 3'd0, 1'b0);
    send_word(64'hDEADBEEF00000000, 3'd4, 1'b1);
    settle();
    check_batch("five_word");

    // Three-word packet, 20-byte B message then a short one.
    exp_q.push_back(ow(1, 0, 0, 64'h0014421122334455));
    exp_q.push_back(ow(0, 0, 0, 64'h66778899AABBCCDD));
    exp_q.push_back(ow(0, 1, 4, 64'hEEFFEEDD00000000));
    exp_q.push_back(ow(1, 1, 4, 64'h0004410100000000));
    send_word({16'h0014, TypeB, 40'h1122334455}, 3'd0, 1'b0);
    send_word(64'h66778899AABBCCDD, 3'd0, 1'b0);
    send_word(64'hEEFFEEDD00044101, 3'd0, 1'b1);
    settle();
    check_batch("three_word");

    // Header straddles the word boundary.
    exp_q.push_back(ow(1, 1, 6, 64'h0006410102030000));
    exp_q.push_back(ow(1, 1, 4, 64'h000441EE00000000));
    send_word(64'h0006410102030004, 3'd0, 1'b0);
    send_word(64'h41EE000000000000, 3'd2, 1'b1);
    settle();
    check_batch("straddle");

    // Length beyond packet end: truncated at the last byte.
    exp_q.push_back(ow(1, 1, 0, 64'h0010440102030405));
    send_word({16'h0010, TypeD, 40'h0102030405}, 3'd0, 1'b1);
    settle();
    check_batch("truncate");

    // Two leftover bytes at packet end are dropped; next packet is clean.
    exp_q.push_back(ow(1, 1, 4, 64'h000441AA00000000));
    exp_q.push_back(ow(1, 1, 4, 64'h000441BB00000000));
    send_word(64'h000441AA00000000, 3'd6, 1'b1);
    send_word(64'h000441BB00000000, 3'd4, 1'b1);
    settle();
    check_batch("tail_drop");

    // L < 3 drops the rest of the packet, including later words.
    exp_q.push_back(ow(1, 1, 4, 64'h0004410100000000));
    exp_q.push_back(ow(1, 1, 4, 64'h000441DD00000000));
    send_word(64'h0004410100024142, 3'd0, 1'b0);
    send_word(64'h0004410000000000, 3'd4, 1'b1);
    send_word(64'h000441DD00000000, 3'd4, 1'b1);
    settle();
    check_batch("framing_err");

    // Reset in the middle of a D message.
    exp_q.push_back(ow(1, 0, 0, 64'h0020440011223344));
    exp_q.push_back(ow(0, 0, 0, 64'h5566778899AABBCC));
    send_word({16'h0020, TypeD, 40'h0011223344}, 3'd0, 1'b0);
    send_word(64'h5566778899AABBCC, 3'd0, 1'b0);
    settle();
    check_batch("pre_reset");
    send_word(64'h0102030405060708, 3'd0, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    chk("reset_mid", {InBus_DataAck, OutBus_Valid, OutBus_Start_Msg, OutBus_End_Msg,
                      OutBus_Mod, OutBus_Data}, 72'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    exp_q.push_back(ow(1, 1, 4, 64'h000441FF00000000));
    send_word(64'h000441FF00000000, 3'd4, 1'b1);
    settle();
    check_batch("post_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
